dcache_mem_responder: RTL and testbench

DCACHE_MEM_RESPONDER -- requirements
Module: dcache_mem_responder

---
 rtl/dcache_pkg.sv | 23 ++
 rtl/resp_sram.sv | 24 ++
 rtl/dcache_mem_responder.sv | 134 +++++++++++++
 tb/tb_dcache_mem_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared dcache definitions: responder FSM states and line geometry.
`ifndef DCACHE_B
`define DCACHE_B 4
`endif

package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_BURST = 2'd2,
    WR_BURST = 2'd3
  } dcache_state_e;

  // 32-bit words per line for the configured byte-offset width
  localparam int DCACHE_LINE_WORDS = 2 ** (`DCACHE_B - 2);

  // Word index of the first word of the line holding byte address addr
  function automatic logic [29:0] line_base(input logic [31:0] addr, input int ow);
    return 30'((addr >> 2) & ~((32'd1 << (ow - 2)) - 32'd1));
  endfunction

endpackage

// File: rtl/resp_sram.sv
// 1R1W word array with registered read data (one-cycle read latency).
module resp_sram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dcache_mem_responder.sv
// Behavioural memory slave for the dcache: line-burst reads after a fixed
// latency, and write-back bursts with wlast protocol checking.
`ifndef DCACHE_B
`define DCACHE_B 4
`endif

module dcache_mem_responder import dcache_pkg::*; #(
  parameter int OFFSET_WIDTH = `DCACHE_B,
  parameter int LINE_WORDS   = DCACHE_LINE_WORDS,
  parameter int MEM_WORDS    = 1024,
  parameter int RD_LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_wlast,
  output logic        mem_addr_ok,
  output logic        mem_data_ok,
  output logic [31:0] mem_rdata,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int BW = $clog2(LINE_WORDS + 1);
  localparam int WW = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
  localparam logic [WW-1:0] LAST_WAIT = WW'(RD_LATENCY - 1);
  localparam dcache_state_e FIRST_RD  = (RD_LATENCY == 0) ? RD_BURST : RD_WAIT;

  dcache_state_e state_q, state_d;
  logic [29:0]   base_q, base_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          addr_ok_q, addr_ok_d;
  logic          data_ok_q, data_ok_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          sram_we;
  logic [AW-1:0] sram_waddr, sram_raddr;
  logic [31:0]   sram_rdata;
  logic          last_beat;

  assign last_beat = (beat_q == LAST_BEAT);

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    beat_d    = beat_q;
    wait_d    = wait_q;
    addr_ok_d = 1'b0;
    data_ok_d = 1'b0;
    err_d     = err_q;
    rdata_d   = rdata_q;
    sram_we   = 1'b0;
    unique case (state_q)
      IDLE: if (mem_req) begin
        addr_ok_d = 1'b1;
        base_d    = line_base(mem_addr, OFFSET_WIDTH);
        beat_d    = '0;
        wait_d    = '0;
        state_d   = mem_wr ? WR_BURST : FIRST_RD;
      end
      RD_WAIT: begin
        wait_d = wait_q + 1'b1;
        if (wait_q == LAST_WAIT) state_d = RD_BURST;
      end
      RD_BURST: begin
        data_ok_d = 1'b1;
        rdata_d   = sram_rdata;
        beat_d    = beat_q + 1'b1;
        if (last_beat) state_d = IDLE;
      end
      WR_BURST: if (mem_req) begin
        sram_we   = 1'b1;
        data_ok_d = 1'b1;
        beat_d    = beat_q + 1'b1;
        if (mem_wlast != last_beat) err_d = 1'b1;
        if (last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    sram_waddr = AW'(base_q + 30'(beat_q));
    // Read one cycle ahead from next-state pointers so the SRAM latency is
    // hidden; this covers the zero-latency case where beat 0 is read in IDLE.
    sram_raddr = AW'(base_d + 30'(beat_d));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      beat_q    <= '0;
      wait_q    <= '0;
      addr_ok_q <= 1'b0;
      data_ok_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      beat_q    <= beat_d;
      wait_q    <= wait_d;
      addr_ok_q <= addr_ok_d;
      data_ok_q <= data_ok_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  resp_sram #(.DEPTH(MEM_WORDS), .AW(AW)) u_sram (
    .clk   (clk),
    .we    (sram_we),
    .waddr (sram_waddr),
    .wdata (mem_wdata),
    .raddr (sram_raddr),
    .rdata (sram_rdata)
  );

  assign mem_addr_ok = addr_ok_q;
  assign mem_data_ok = data_ok_q;
  assign mem_rdata   = rdata_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Scenario bench for dcache_mem_responder against a word-array memory model.
module tb_dcache_mem_responder;

  localparam int LW  = 4;
  localparam int LAT = 2;
  localparam int MW  = 1024;

  logic        clk = 1'b0;
  logic        reset, mem_req, mem_wr, mem_wlast;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok, busy, err;

  int          total = 0;
  int          passed = 0;
  bit          err_exp;
  logic [31:0] model [MW];
  logic [31:0] wq [$];

  dcache_mem_responder #(.MEM_WORDS(MW), .RD_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wlast(mem_wlast),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // 16-byte lines of 4 words; memory wraps at MW words
  function automatic int midx(input logic [31:0] a, input int k);
    return (int'(a >> 4) * LW + k) % MW;
  endfunction

  task automatic write_line(input logic [31:0] addr, input logic [3:0][31:0] d,
                            input int wl_pos, input bit gaps, input bit chain,
                            input logic [31:0] chain_addr);
    int k;
    mem_req = 1'b1; mem_wr = 1'b1; mem_addr = addr; mem_wlast = 1'b0;
    tick;
    total++; if (mem_addr_ok !== 1'b1) $display("FAIL wr_addr_ok got=%b exp=1", mem_addr_ok); else passed++;
    k = 0;
    while (k < LW) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        mem_req = 1'b0;
        tick;
        total++; if (mem_data_ok !== 1'b0) $display("FAIL wr_gap_ack got=%b exp=0", mem_data_ok); else passed++;
      end else begin
        mem_req = 1'b1; mem_wdata = d[k]; mem_wlast = (k == wl_pos);
        if (chain && k == LW - 1) begin mem_wr = 1'b0; mem_addr = chain_addr; end
        model[midx(addr, k)] = d[k];
        if ((k == LW - 1) != (k == wl_pos)) err_exp = 1'b1;
        tick;
        total++; if (mem_data_ok !== 1'b1) $display("FAIL wr_ack beat=%0d got=%b exp=1", k, mem_data_ok); else passed++;
        k++;
      end
    end
    if (!chain) mem_req = 1'b0;
    mem_wlast = 1'b0;
    wq.push_back(addr);
    total++; if (busy !== 1'b0) $display("FAIL wr_end_busy got=%b exp=0", busy); else passed++;
    total++; if (err !== err_exp) $display("FAIL wr_err got=%b exp=%b", err, err_exp); else passed++;
  endtask

  // Checks the read data phase; call in the cycle addr_ok is visible.
  task automatic read_beats(input logic [31:0] addr);
    logic [31:0] last;
    for (int i = 0; i < LAT; i++) begin
      tick;
      total++; if (mem_data_ok !== 1'b0) $display("FAIL rd_wait cyc=%0d got=%b exp=0", i, mem_data_ok); else passed++;
    end
    for (int k = 0; k < LW; k++) begin
      tick;
      last = model[midx(addr, k)];
      total++; if (mem_data_ok !== 1'b1) $display("FAIL rd_valid beat=%0d got=%b exp=1", k, mem_data_ok); else passed++;
      total++; if (mem_rdata !== last) $display("FAIL rd_data addr=%h beat=%0d got=%h exp=%h", addr, k, mem_rdata, last); else passed++;
    end
    tick;
    total++; if (mem_data_ok !== 1'b0) $display("FAIL rd_end_valid got=%b exp=0", mem_data_ok); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rd_end_busy got=%b exp=0", busy); else passed++;
    total++; if (mem_rdata !== last) $display("FAIL rd_hold got=%h exp=%h", mem_rdata, last); else passed++;
  endtask

  task automatic read_line(input logic [31:0] addr);
    mem_req = 1'b1; mem_wr = 1'b0; mem_addr = addr;
    tick;
    total++; if (mem_addr_ok !== 1'b1) $display("FAIL rd_addr_ok got=%b exp=1", mem_addr_ok); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL rd_busy got=%b exp=1", busy); else passed++;
    mem_req = 1'b0;
    read_beats(addr);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    total++; if (mem_addr_ok !== 1'b0) $display("FAIL rst_addr_ok got=%b exp=0", mem_addr_ok); else passed++;
    total++; if (mem_data_ok !== 1'b0) $display("FAIL rst_data_ok got=%b exp=0", mem_data_ok); else passed++;
    total++; if (mem_rdata !== 32'h0) $display("FAIL rst_rdata got=%h exp=0", mem_rdata); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else passed++;
    total++; if (err !== 1'b0) $display("FAIL rst_err got=%b exp=0", err); else passed++;
    reset = 1'b0;
    err_exp = 1'b0;
  endtask

  task automatic test_read_basic;
    logic [3:0][31:0] d;
    for (int k = 0; k < LW; k++) d[k] = 32'hA0 + k;
    write_line(32'h10, d, LW - 1, 1'b0, 1'b0, 32'h0);
    read_line(32'h14);
  endtask

  task automatic test_write_read;
    logic [3:0][31:0] d;
    d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33; d[3] = 32'h44;
    write_line(32'h20, d, LW - 1, 1'b0, 1'b0, 32'h0);
    read_line(32'h2C);
  endtask

  task automatic test_wlast_err;
    logic [3:0][31:0] d;
    for (int k = 0; k < LW; k++) d[k] = $urandom;
    write_line(32'h40, d, 1, 1'b0, 1'b0, 32'h0);
    read_line(32'h48);
    total++; if (err !== 1'b1) $display("FAIL err_sticky got=%b exp=1", err); else passed++;
  endtask

  task automatic test_reset_mid;
    mem_req = 1'b1; mem_wr = 1'b0; mem_addr = 32'h14;
    tick;
    mem_req = 1'b0;
    for (int i = 0; i < LAT; i++) tick;
    tick;
    total++; if (mem_rdata !== model[4]) $display("FAIL mid_beat0 got=%h exp=%h", mem_rdata, model[4]); else passed++;
    tick;
    total++; if (mem_rdata !== model[5]) $display("FAIL mid_beat1 got=%h exp=%h", mem_rdata, model[5]); else passed++;
    reset = 1'b1;
    tick;
    total++; if (mem_data_ok !== 1'b0) $display("FAIL mid_rst_data_ok got=%b exp=0", mem_data_ok); else passed++;
    total++; if (mem_rdata !== 32'h0) $display("FAIL mid_rst_rdata got=%h exp=0", mem_rdata); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got=%b exp=0", busy); else passed++;
    total++; if (err !== 1'b0) $display("FAIL mid_rst_err got=%b exp=0", err); else passed++;
    total++; if (mem_addr_ok !== 1'b0) $display("FAIL mid_rst_addr_ok got=%b exp=0", mem_addr_ok); else passed++;
    reset = 1'b0;
    err_exp = 1'b0;
    read_line(32'h14);
  endtask

  task automatic test_ignore_busy;
    logic [31:0] a, b;
    int beats;
    bit got, pb;
    a = 32'h24; b = 32'hABC0_0018;
    mem_req = 1'b1; mem_wr = 1'b0; mem_addr = a;
    tick;
    total++; if (mem_addr_ok !== 1'b1) $display("FAIL ib_addr_ok got=%b exp=1", mem_addr_ok); else passed++;
    mem_addr = b;
    beats = 0; got = 1'b0; pb = busy;
    for (int i = 0; i < 16 && !got; i++) begin
      tick;
      if (mem_addr_ok) got = 1'b1;
      else begin
        pb = busy;
        if (mem_data_ok) begin
          total++;
          if (mem_rdata !== model[midx(a, beats)]) $display("FAIL ib_data beat=%0d got=%h exp=%h", beats, mem_rdata, model[midx(a, beats)]);
          else passed++;
          beats++;
        end
      end
    end
    mem_req = 1'b0;
    total++; if (got !== 1'b1) $display("FAIL ib_accept got=%b exp=1", got); else passed++;
    total++; if (pb !== 1'b0) $display("FAIL ib_busy_before got=%b exp=0", pb); else passed++;
    total++; if (beats != LW) $display("FAIL ib_beats got=%0d exp=%0d", beats, LW); else passed++;
    if (got) read_beats(b);
  endtask

  task automatic test_back_to_back;
    logic [3:0][31:0] d;
    bit got, pb;
    for (int k = 0; k < LW; k++) d[k] = $urandom;
    write_line(32'h300, d, LW - 1, 1'b0, 1'b1, 32'h4010);
    got = 1'b0; pb = busy;
    for (int i = 0; i < 10 && !got; i++) begin
      tick;
      if (mem_addr_ok) got = 1'b1; else pb = busy;
    end
    mem_req = 1'b0;
    total++; if (got !== 1'b1) $display("FAIL b2b_accept got=%b exp=1", got); else passed++;
    total++; if (pb !== 1'b0) $display("FAIL b2b_busy_before got=%b exp=0", pb); else passed++;
    if (got) read_beats(32'h4010);
  endtask

  task automatic test_random;
    logic [3:0][31:0] d;
    logic [31:0] a;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < LW; k++) d[k] = $urandom;
        a = $urandom;
        write_line(a, d, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : LW - 1,
                   1'b1, 1'b0, 32'h0);
      end else begin
        a = wq[$urandom_range(0, wq.size() - 1)];
        a = (a & 32'h0000_0FF0) | ($urandom & 32'hFFFF_F00F);
        read_line(a);
      end
    end
  endtask

  initial begin
    reset = 1'b1; mem_req = 1'b0; mem_wr = 1'b0; mem_wlast = 1'b0;
    mem_addr = '0; mem_wdata = '0; err_exp = 1'b0;
    test_reset;
    test_read_basic;
    test_write_read;
    test_wlast_err;
    test_reset_mid;
    test_ignore_busy;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
